// File: rtl/vga_timing_gen.sv
// vga_timing_gen: pixel-clock enable, horizontal/vertical counters and a
// registered output stage. rgb, hsync and vsync are registered together on
// p_tick, so they trail x,y by exactly one pixel and stay aligned.
// Optional feature: define VGA_FRAME_CNT_EN to add a 16-bit frame counter
// output (frame_cnt).
module vga_timing_gen #(
   parameter int unsigned CLK_DIV   = 4,
   parameter int unsigned H_DISPLAY = 640,
   parameter int unsigned H_FRONT   = 16,
   parameter int unsigned H_SYNC    = 96,
   parameter int unsigned H_BACK    = 48,
   parameter int unsigned V_DISPLAY = 480,
   parameter int unsigned V_FRONT   = 10,
   parameter int unsigned V_SYNC    = 2,
   parameter int unsigned V_BACK    = 33,
   parameter int unsigned HS_POL    = 0,
   parameter int unsigned VS_POL    = 0,
   parameter int unsigned COORD_W   = 10,
   parameter int unsigned RGB_W     = 12
) (
   input  logic               clk_100MHz,
   input  logic               reset,
   input  logic [RGB_W-1:0]   rgb_in,
   output logic               p_tick,
   output logic [COORD_W-1:0] x,
   output logic [COORD_W-1:0] y,
   output logic               video_on,
   output logic               hsync,
   output logic               vsync,
   output logic [RGB_W-1:0]   rgb,
   output logic               line_start,
   output logic               frame_start
`ifdef VGA_FRAME_CNT_EN
   ,
   output logic [15:0]        frame_cnt
`endif
);

   localparam int unsigned H_TOTAL  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
   localparam int unsigned V_TOTAL  = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
   localparam int unsigned HS_START = H_DISPLAY + H_FRONT;
   localparam int unsigned HS_END   = H_DISPLAY + H_FRONT + H_SYNC;
   localparam int unsigned VS_START = V_DISPLAY + V_FRONT;
   localparam int unsigned VS_END   = V_DISPLAY + V_FRONT + V_SYNC;
   localparam int unsigned DIV_W    = $clog2(CLK_DIV);

   localparam logic [DIV_W-1:0]   L_DIV_MAX = DIV_W'(CLK_DIV - 1);
   localparam logic [COORD_W-1:0] L_H_MAX   = COORD_W'(H_TOTAL - 1);
   localparam logic [COORD_W-1:0] L_V_MAX   = COORD_W'(V_TOTAL - 1);
   localparam logic               L_HS_ON   = (HS_POL != 0);
   localparam logic               L_VS_ON   = (VS_POL != 0);

   logic [DIV_W-1:0]   r_div;
   logic [COORD_W-1:0] r_h_cnt;
   logic [COORD_W-1:0] r_v_cnt;
   logic               r_hsync;
   logic               r_vsync;
   logic [RGB_W-1:0]   r_rgb;

   logic               w_tick;
   logic               w_h_last;
   logic               w_v_last;
   logic [31:0]        w_h32;
   logic [31:0]        w_v32;
   logic               w_video_on;
   logic               w_hs_act;
   logic               w_vs_act;

   // Compares are done at 32 bits so sync ends equal to the total do not
   // overflow COORD_W.
   assign w_h32      = 32'(r_h_cnt);
   assign w_v32      = 32'(r_v_cnt);
   assign w_tick     = (r_div == L_DIV_MAX);
   assign w_h_last   = (r_h_cnt == L_H_MAX);
   assign w_v_last   = (r_v_cnt == L_V_MAX);
   assign w_video_on = (w_h32 < H_DISPLAY) && (w_v32 < V_DISPLAY);
   assign w_hs_act   = (w_h32 >= HS_START) && (w_h32 < HS_END);
   assign w_vs_act   = (w_v32 >= VS_START) && (w_v32 < VS_END);

   // Pixel-rate divider: wraps at CLK_DIV-1, which is also the tick cycle.
   always_ff @(posedge clk_100MHz) begin
      if (reset)       r_div <= '0;
      else if (w_tick) r_div <= '0;
      else             r_div <= r_div + DIV_W'(1);
   end

   // Horizontal and vertical position counters, advanced once per pixel.
   always_ff @(posedge clk_100MHz) begin
      if (reset) begin
         r_h_cnt <= '0;
         r_v_cnt <= '0;
      end else if (w_tick) begin
         if (w_h_last) begin
            r_h_cnt <= '0;
            if (w_v_last) r_v_cnt <= '0;
            else          r_v_cnt <= r_v_cnt + COORD_W'(1);
         end else begin
            r_h_cnt <= r_h_cnt + COORD_W'(1);
         end
      end
   end

   // Output stage: capture sync and colour for the pixel being presented.
   always_ff @(posedge clk_100MHz) begin
      if (reset) begin
         r_hsync <= ~L_HS_ON;
         r_vsync <= ~L_VS_ON;
         r_rgb   <= '0;
      end else if (w_tick) begin
         r_hsync <= w_hs_act ? L_HS_ON : ~L_HS_ON;
         r_vsync <= w_vs_act ? L_VS_ON : ~L_VS_ON;
         r_rgb   <= w_video_on ? rgb_in : '0;
      end
   end

`ifdef VGA_FRAME_CNT_EN
   logic [15:0] r_frame_cnt;

   // Free-running frame counter, wraps naturally at 16 bits.
   always_ff @(posedge clk_100MHz) begin
      if (reset)            r_frame_cnt <= '0;
      else if (frame_start) r_frame_cnt <= r_frame_cnt + 16'd1;
   end

   assign frame_cnt = r_frame_cnt;
`endif

   assign p_tick      = w_tick;
   assign x           = r_h_cnt;
   assign y           = r_v_cnt;
   assign video_on    = w_video_on;
   assign hsync       = r_hsync;
   assign vsync       = r_vsync;
   assign rgb         = r_rgb;
   assign line_start  = w_tick && w_h_last;
   assign frame_start = w_tick && w_h_last && w_v_last;

endmodule
